// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: synchronises the serial stream, validates 11-bit frames,
// buffers good bytes in a FIFO and tracks make/break codes for the current key.
module ps2_scan_decoder #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keybuffer,
  output logic       key_down,
  output logic       key_ext,
  output logic [7:0] press_count,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  logic [2:0]    clk_sync_q, dat_sync_q;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;
  state_t        state_q, state_d;
  logic [7:0]    keybuffer_q, keybuffer_d;
  logic          key_down_q, key_down_d;
  logic          key_ext_q, key_ext_d;
  logic [7:0]    press_count_q, press_count_d;

  logic       fall_c, bit_c, frame_done_c, frame_ok_c;
  logic       empty_c, full_c, wr_en_c, pop_c;
  logic [7:0] code_c;
  logic       do_make_c, do_brk_c, ext_v_c;

  // Edge detect: oldest sync stage high, next stage low.
  assign fall_c       = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_c        = dat_sync_q[2];
  assign frame_done_c = fall_c && (bit_cnt_q == 4'd10);
  assign frame_ok_c   = frame_done_c && !shift_q[0] && bit_c && (^shift_q[9:1]);

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en_c = frame_ok_c && !full_c;
  assign pop_c   = !empty_c;
  assign code_c  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = frame_done_c && !frame_ok_c;
    overflow_d  = overflow_q | (frame_ok_c & full_c);
    if (fall_c) begin
      bit_cnt_d = frame_done_c ? 4'd0 : bit_cnt_q + 4'd1;
      shift_d   = {bit_c, shift_q[9:1]};
    end
  end

  // Make/break decoder: one FIFO byte consumed per cycle.
  always_comb begin
    state_d       = state_q;
    keybuffer_d   = keybuffer_q;
    key_down_d    = key_down_q;
    key_ext_d     = key_ext_q;
    press_count_d = press_count_q;
    do_make_c     = 1'b0;
    do_brk_c      = 1'b0;
    ext_v_c       = 1'b0;
    if (pop_c) begin
      case (state_q)
        S_IDLE: begin
          if (code_c == 8'hE0)      state_d = S_EXT;
          else if (code_c == 8'hF0) state_d = S_BRK;
          else                      do_make_c = 1'b1;
        end
        S_EXT: begin
          if (code_c == 8'hF0)      state_d = S_EXT_BRK;
          else if (code_c != 8'hE0) begin
            do_make_c = 1'b1;
            ext_v_c   = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_BRK: begin
          if (code_c == 8'hE0) state_d = S_EXT_BRK;
          else begin
            do_brk_c = 1'b1;
            state_d  = S_IDLE;
          end
        end
        default: begin
          do_brk_c = 1'b1;
          ext_v_c  = 1'b1;
          state_d  = S_IDLE;
        end
      endcase
    end
    // A make matching the held key is typematic repeat and changes nothing.
    if (do_make_c && !(key_down_q && keybuffer_q == code_c && key_ext_q == ext_v_c)) begin
      keybuffer_d   = code_c;
      key_ext_d     = ext_v_c;
      key_down_d    = 1'b1;
      press_count_d = press_count_q + 8'd1;
    end
    if (do_brk_c && keybuffer_q == code_c && key_ext_q == ext_v_c) begin
      key_down_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q    <= 3'b111;
      dat_sync_q    <= 3'b111;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 10'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      frame_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
      state_q       <= S_IDLE;
      keybuffer_q   <= 8'd0;
      key_down_q    <= 1'b0;
      key_ext_q     <= 1'b0;
      press_count_q <= 8'd0;
    end else begin
      clk_sync_q    <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q    <= {dat_sync_q[1:0], ps2_data};
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      if (wr_en_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)   rd_ptr_q <= rd_ptr_q + PW'(1);
      frame_err_q   <= frame_err_d;
      overflow_q    <= overflow_d;
      state_q       <= state_d;
      keybuffer_q   <= keybuffer_d;
      key_down_q    <= key_down_d;
      key_ext_q     <= key_ext_d;
      press_count_q <= press_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_ptr_q[AW-1:0]] <= shift_q[8:1];
  end

  assign keybuffer   = keybuffer_q;
  assign key_down    = key_down_q;
  assign key_ext     = key_ext_q;
  assign press_count = press_count_q;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;

endmodule
